// File: rtl/branch_pkg.sv
// Shared types for the branch resolution stage: funct3 codes, skid FSM states,
// and the registered result payload.
package branch_pkg;

   localparam int BR_XLEN = 32;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } branch_funct3_t;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'd0,
      SK_ONE   = 2'd1,
      SK_TWO   = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic               taken;
      logic               mispredict;
      logic               illegal;
      logic [BR_XLEN-1:0] pc;
   } branch_result_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Upstream and downstream valid/ready channels of the branch resolution stage.
interface branch_resolve_if #(parameter int N = 32);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_funct3;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic [N-1:0] in_pc;
   logic         in_pred_taken;
   logic         out_valid;
   logic         out_ready;
   logic         out_taken;
   logic         out_mispredict;
   logic         out_illegal;
   logic [N-1:0] out_pc;

   modport slave (
      input  in_valid, in_funct3, in_a, in_b, in_pc, in_pred_taken, out_ready,
      output in_ready, out_valid, out_taken, out_mispredict, out_illegal, out_pc
   );

   modport master (
      output in_valid, in_funct3, in_a, in_b, in_pc, in_pred_taken, out_ready,
      input  in_ready, out_valid, out_taken, out_mispredict, out_illegal, out_pc
   );
endinterface

// File: rtl/branch_skid.sv
// Two-entry skid buffer; output always shows the oldest entry (main slot).
//   state    | meaning
//   SK_EMPTY | no entries, out_valid low
//   SK_ONE   | main slot holds one entry
//   SK_TWO   | main and skid slots full, in_ready low
module branch_skid
   import branch_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   skid_state_t  state, state_nx;
   logic [W-1:0] main_q, skid_q;
   logic         in_hs, out_hs;
   logic         load_main_in, load_main_skid, load_skid;

   assign in_ready  = (state != SK_TWO);
   assign out_valid = (state != SK_EMPTY);
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign out_data  = main_q;

   always_comb begin
      state_nx       = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         SK_EMPTY: begin
            if (in_hs) begin
               state_nx     = SK_ONE;
               load_main_in = 1'b1;
            end
         end
         SK_ONE: begin
            case ({in_hs, out_hs})
               2'b10: begin
                  state_nx  = SK_TWO;
                  load_skid = 1'b1;
               end
               2'b01: state_nx = SK_EMPTY;
               2'b11: load_main_in = 1'b1;
               default: state_nx = SK_ONE;
            endcase
         end
         SK_TWO: begin
            if (out_hs) begin
               state_nx       = SK_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_nx = SK_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SK_EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nx;
         if (load_main_in)
            main_q <= in_data;
         else if (load_main_skid)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= in_data;
      end
   end
endmodule

// File: rtl/comparator_eq.sv
// Operand equality comparator.
module comparator_eq #(parameter int N = 32) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         eq
);
   assign eq = (a == b);
endmodule

// File: rtl/comparator_lt.sv
// Signed less-than comparator; unsigned compares reuse it with MSBs inverted.
module comparator_lt #(parameter int N = 32) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   assign lt = ($signed(a) < $signed(b));
endmodule

// File: rtl/branch_resolve.sv
// Branch condition evaluation feeding a two-entry skid buffer.
// Optional BRANCH_RESOLVE_STATS_EN adds a saturating mispredict counter.
module branch_resolve
   import branch_pkg::*;
#(
   parameter int N = 32
) (
   input  logic              clk,
   input  logic              rst,
   branch_resolve_if.slave   bus
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]       mispredict_count
`endif
);
   logic           eq, lt, ltu, taken, illegal;
   logic [N-1:0]   a_u, b_u;
   branch_result_t res_in, res_out;

   // Inverting both MSBs maps unsigned order onto signed order.
   assign a_u = {~bus.in_a[N-1], bus.in_a[N-2:0]};
   assign b_u = {~bus.in_b[N-1], bus.in_b[N-2:0]};

   comparator_eq #(.N(N)) u_eq  (.a(bus.in_a), .b(bus.in_b), .eq(eq));
   comparator_lt #(.N(N)) u_lt  (.a(bus.in_a), .b(bus.in_b), .lt(lt));
   comparator_lt #(.N(N)) u_ltu (.a(a_u),      .b(b_u),      .lt(ltu));

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (bus.in_funct3)
         F3_BEQ:  taken = eq;
         F3_BNE:  taken = ~eq;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = ~lt;
         F3_BLTU: taken = ltu;
         F3_BGEU: taken = ~ltu;
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      res_in.taken      = taken;
      res_in.mispredict = ~illegal & (taken ^ bus.in_pred_taken);
      res_in.illegal    = illegal;
      res_in.pc         = BR_XLEN'(bus.in_pc);
   end

   branch_skid #(.W($bits(branch_result_t))) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (res_in),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (res_out)
   );

   assign bus.out_taken      = res_out.taken;
   assign bus.out_mispredict = res_out.mispredict;
   assign bus.out_illegal    = res_out.illegal;
   assign bus.out_pc         = N'(res_out.pc);

`ifdef BRANCH_RESOLVE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         mispredict_count <= '0;
      else if (bus.out_valid && bus.out_ready && bus.out_mispredict &&
               (mispredict_count != 32'hFFFF_FFFF))
         mispredict_count <= mispredict_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Directed plus randomized bench for branch_resolve against a queue-based reference model.
module tb_branch_resolve;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_resolve_if #(.N(32)) bus ();
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] mispredict_count;
`endif

   branch_resolve #(.N(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef BRANCH_RESOLVE_STATS_EN
      , .mispredict_count (mispredict_count)
`endif
   );

   typedef struct {
      logic        t;
      logic        m;
      logic        i;
      logic [31:0] pc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] exp_cnt = 0;
   int          checks  = 0;
   int          fails   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_eval(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] pc, input logic p);
      exp_t e;
      e.i = 1'b0;
      e.t = 1'b0;
      e.pc = pc;
      case (f)
         3'd0: e.t = (a == b);
         3'd1: e.t = (a != b);
         3'd4: e.t = ($signed(a) <  $signed(b));
         3'd5: e.t = ($signed(a) >= $signed(b));
         3'd6: e.t = (a <  b);
         3'd7: e.t = (a >= b);
         default: e.i = 1'b1;
      endcase
      e.m = e.i ? 1'b0 : (e.t != p);
      return e;
   endfunction

   task automatic check_outputs();
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (q.size() < 2)});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (q.size() > 0)});
      if (q.size() > 0) begin
         chk("out_taken", {31'd0, bus.out_taken}, {31'd0, q[0].t});
         chk("out_mispredict", {31'd0, bus.out_mispredict}, {31'd0, q[0].m});
         chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].i});
         chk("out_pc", bus.out_pc, q[0].pc);
      end
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("mispredict_count", mispredict_count, exp_cnt);
`endif
   endtask

   // Drive one cycle of stimulus, advance the model at the edge, check at the next negedge.
   task automatic step(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic p, input logic ordy);
      bit ihs, ohs;
      bus.in_valid      = v;
      bus.in_funct3     = f;
      bus.in_a          = a;
      bus.in_b          = b;
      bus.in_pc         = pc;
      bus.in_pred_taken = p;
      bus.out_ready     = ordy;
      ihs = v && (q.size() < 2);
      ohs = ordy && (q.size() > 0);
      @(posedge clk);
      if (ohs) begin
         if (q[0].m && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
         void'(q.pop_front());
      end
      if (ihs) q.push_back(ref_eval(f, a, b, pc, p));
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      check_outputs();
      chk("rst_taken", {31'd0, bus.out_taken}, 32'd0);
      chk("rst_mispredict", {31'd0, bus.out_mispredict}, 32'd0);
      chk("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
      chk("rst_pc", bus.out_pc, 32'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      bus.in_valid = 0; bus.in_funct3 = 0; bus.in_a = 0; bus.in_b = 0;
      bus.in_pc = 0; bus.in_pred_taken = 0; bus.out_ready = 0;
      @(negedge clk);
      do_reset();

      // Signed versus unsigned on the same operands.
      step(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 0, 1);
      step(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h104, 0, 1);
      step(1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h108, 0, 1);
      step(1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h10C, 1, 1);
      // Back-to-back BEQ/BNE with equal operands.
      step(1, 3'b000, 32'h1234, 32'h1234, 32'h200, 1, 1);
      step(1, 3'b001, 32'h1234, 32'h1234, 32'h204, 1, 1);
      step(0, 3'b000, 0, 0, 0, 0, 1);
      // Backpressure: third push stalls until the buffer leaves TWO.
      step(1, 3'b000, 32'd5, 32'd5, 32'h300, 0, 0);
      step(1, 3'b001, 32'd5, 32'd6, 32'h304, 0, 0);
      step(1, 3'b100, 32'd1, 32'd2, 32'h308, 1, 0);
      step(1, 3'b100, 32'd1, 32'd2, 32'h308, 1, 0);
      step(1, 3'b100, 32'd1, 32'd2, 32'h308, 1, 1);
      step(1, 3'b100, 32'd1, 32'd2, 32'h308, 1, 1);
      step(0, 3'b000, 0, 0, 0, 0, 1);
      step(0, 3'b000, 0, 0, 0, 0, 1);
      // Illegal funct3 codes.
      step(1, 3'b010, 32'd7, 32'd7, 32'h400, 1, 1);
      step(1, 3'b011, 32'd7, 32'd8, 32'h404, 0, 1);
      step(0, 3'b000, 0, 0, 0, 0, 1);

      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      end

      // Five mispredicts, then reset with one entry buffered.
      do_reset();
      for (int i = 0; i < 5; i++)
         step(1, 3'b000, 32'd9, 32'd9, 32'h500 + 32'(i * 4), 0, 1);
      step(0, 3'b000, 0, 0, 0, 0, 1);
      step(1, 3'b001, 32'd1, 32'd2, 32'h600, 0, 0);
      do_reset();
      step(0, 3'b000, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Registered branch-resolution stage sitting directly downstream of the operand comparators in the execute path. Accepts a branch µop (funct3, rs1/rs2 values, PC, predicted direction), evaluates the six RV32 branch conditions using `comparator_lt` / `comparator_eq`, and hands a taken/mispredict decision to the writeback/fetch-redirect logic. A 2-entry skid buffer with valid/ready handshakes decouples upstream from downstream backpressure.

## Interface
Parameters:
- `N`, 32, operand and PC width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream µop valid.
- `in_ready`  out  1  stage can accept; function of internal state only.
- `in_funct3`  in  3  branch type (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- `in_a`, `in_b`  in  N  rs1, rs2 values.
- `in_pc`  in  N  branch PC, passed through.
- `in_pred_taken`  in  1  predictor's direction.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_taken`  out  1  resolved direction.
- `out_mispredict`  out  1  `out_taken != pred_taken`, forced 0 when illegal.
- `out_illegal`  out  1  funct3 010 or 011.
- `out_pc`  out  N  PC of the reported µop.
- `mispredict_count`  out  32  only with `BRANCH_RESOLVE_STATS_EN`.

## Operation
- Condition evaluated combinationally on input side, registered into buffer with pc/pred/illegal.
- eq via `comparator_eq(in_a, in_b)`; signed lt via `comparator_lt(in_a, in_b)`.
- Unsigned lt: same `comparator_lt` fed with bit N-1 of both operands inverted; no separate unsigned comparator.
- BEQ=eq, BNE=~eq, BLT=lt, BGE=~lt, BLTU=ltu, BGEU=~ltu; illegal funct3 → taken 0, mispredict 0, illegal 1.
- Skid buffer FSM: EMPTY, ONE, TWO.
  - EMPTY: in handshake → ONE.
  - ONE: in only → TWO; out only → EMPTY; both → ONE (main slot replaced by the new µop).
  - TWO: out handshake → ONE (skid slot shifts to main); no input accepted.
- `in_ready` = state != TWO. `out_valid` = state != EMPTY. Output always presents the oldest µop; strict FIFO order.
- Output fields held stable while `out_valid & ~out_ready`.

## Timing
- Latency: 1 cycle from input handshake to `out_valid` when EMPTY/ONE-draining.
- Throughput: 1 µop/cycle with `out_ready` held high.
- No combinational path from `out_ready` to `in_ready` or from inputs to outputs.
- Reset: state EMPTY; `in_ready` 1, `out_valid` 0, `out_taken` 0, `out_mispredict` 0, `out_illegal` 0, `out_pc` 0, `mispredict_count` 0.
- `rst` mid-operation discards buffered µops; no output handshake in that cycle.
- Simultaneous in/out handshake in ONE: count remains 1, new µop visible next cycle.

## Configuration
- `BRANCH_RESOLVE_STATS_EN` defined: 32-bit `mispredict_count` increments on each output handshake with `out_mispredict`=1; saturates at 0xFFFF_FFFF; cleared by `rst`.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package `branch_pkg`: `branch_funct3_t` enum (six legal codes), FSM state enum, packed result struct (taken, mispredict, illegal, pc).
- Sub-module `branch_skid` (parameterised on payload width): the EMPTY/ONE/TWO buffer; `branch_resolve` holds condition logic, comparator instances, and stats counter.

## Test plan
- BLT a=0xFFFF_FFFF, b=1, pred 0, out_ready 1 → next cycle out_valid 1, taken 1, mispredict 1.
- BLTU same operands, pred 0 → taken 0, mispredict 0; BGEU → taken 1.
- BEQ a=b=0x1234 then BNE same → taken 1 then 0, back-to-back, in_ready never drops.
- out_ready 0, push three µops → in_ready falls after second accept; release → pcs emerge in order, third accepted once state leaves TWO.
- funct3=010 → out_illegal 1, taken 0, mispredict 0; count unchanged.
- With `BRANCH_RESOLVE_STATS_EN`: 5 mispredicts, assert rst with 1 µop buffered → count 0, out_valid 0 next cycle, in_ready 1.
